regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised successor to the 16x16 CPU register file. Two combinational read ports with
//  write-to-read bypass, one write port, and R0 hardwired to zero. Adds a per-register pending-write
//  scoreboard that flags read-after-write hazards so decode can stall. Sits between decode (reads,
//  issue) and writeback (write); addr_sw/data_sw feed the store-word data path.
// PARAMETERS
//  DATA_W    16   register width in bits
//  ADDR_W    4    register address width; NREGS = 2**ADDR_W
//  BYPASS    1    1: same-cycle write forwarded to read ports; 0: read returns stored value only
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  add_Rs     in   ADDR_W   read port S address
//  add_Rt     in   ADDR_W   read port T address
//  out_Rs     out  DATA_W   read port S data
//  out_Rt     out  DATA_W   read port T data
//  addr_sw    out  DATA_W   copy of out_Rs (store address operand)
//  data_sw    out  DATA_W   copy of out_Rt (store data operand)
//  regwr      in   1        writeback strobe
//  add_Rd     in   ADDR_W   writeback destination
//  data_wr    in   DATA_W   writeback data
//  iss_en     in   1        instruction issued; marks iss_rd pending
//  iss_rd     in   ADDR_W   destination of issued instruction
//  use_Rs     in   1        issuing instruction reads Rs
//  use_Rt     in   1        issuing instruction reads Rt
//  busy_Rs    out  1        Rs has an outstanding write not yet resolved
//  busy_Rt    out  1        Rt has an outstanding write not yet resolved
//  stall      out  1        (use_Rs & busy_Rs) | (use_Rt & busy_Rt)
//  pend_cnt   out  ADDR_W+1 number of registers currently pending
// BEHAVIOUR
//  - Reset (async, rst=1): all registers 0, all pending bits 0, pend_cnt=0; outputs follow
//    combinationally, so out_Rs/out_Rt=0, busy_*=0, stall=0 while reset is held.
//  - Write: at posedge clk when regwr & add_Rd!=0, Register[add_Rd] <= data_wr. A write to R0 is
//    discarded; R0 always reads 0 and is never pending.
//  - Read: combinational, zero latency. Address 0 -> 0. Else if BYPASS & regwr & add_Rd==addr,
//    return data_wr; otherwise return Register[addr]. Port S and port T are independent; Rs==Rt legal.
//  - Scoreboard bit per reg: set at posedge on iss_en & iss_rd!=0; cleared at posedge on regwr
//    & add_Rd matching. Set and clear of the same reg in one cycle -> set wins (new producer
//    outstanding). Set on an already-pending reg stays pending (no count, single outstanding write
//    per reg; a second issue re-arms it).
//  - busy_Rx = pend[add_Rx] & !(BYPASS & regwr & add_Rd==add_Rx); add_Rx==0 -> 0.
//  - stall is combinational from the current-cycle inputs; the block does not hold state for stall.
//  - pend_cnt = popcount of pending bits, registered and updated on the same edge as the bits;
//    range 0..NREGS-1.
//  - regwr to a non-pending reg is legal (plain write, no scoreboard effect).
//  - No simulation $display in synthesised path; tracing is done only under `ifdef SIM.
// STRUCTURE
//  - regfile_pkg: DATA_W/ADDR_W defaults and the R0 constant (ZERO_REG=0).
//  - Sub-module regfile_scoreboard: pending bit vector, set/clear priority, pend_cnt.
//    The top level holds the storage array and the bypass/read muxes.
// TESTING
//  1 rst pulse mid-run after writes to R3=16'h1234 -> all reads 0, pend_cnt=0 with no clk edge.
//  2 regwr add_Rd=0 data_wr=16'hFFFF, then read Rs=0 -> out_Rs=0; pend unaffected.
//  3 regwr add_Rd=5 data_wr=16'hBEEF with add_Rs=5 in the same cycle -> out_Rs=16'hBEEF (BYPASS=1),
//    previous value (BYPASS=0).
//  4 iss_en iss_rd=7; next cycle add_Rt=7 use_Rt=1 -> busy_Rt=1, stall=1, pend_cnt=1; regwr
//    add_Rd=7 same cycle -> busy_Rt=0, stall=0; after edge pend_cnt=0.
//  5 Same cycle iss_en iss_rd=9 and regwr add_Rd=9 -> R9 written and pending remains 1.
//  6 Issue R1..R15 back-to-back -> pend_cnt=15; iss_rd=0 -> no change; DATA_W=32, ADDR_W=5 build
//    repeats tests 3-4.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - default widths and the hardwired-zero register index for regfile_sb
package regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write bits with set-over-clear priority and
// a registered popcount of outstanding writes
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_rd,
  input  logic                   regwr,
  input  logic [ADDR_W-1:0]      add_Rd,
  output logic [(2**ADDR_W)-1:0] pend,
  output logic [ADDR_W:0]        pend_cnt
);
  localparam int NREGS = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [NREGS-1:0] pend_nxt;
  logic [CW-1:0]    cnt_nxt;

  // Set is applied after clear so a new producer issued in the writeback cycle stays outstanding.
  always_comb begin
    pend_nxt = pend;
    if (regwr) pend_nxt[add_Rd] = 1'b0;
    if (iss_en && iss_rd != ADDR_W'(ZERO_REG)) pend_nxt[iss_rd] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-read/one-write register file with optional write bypass, R0 tied to
// zero, and a read-after-write hazard scoreboard driving the decode stall
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] add_Rs,
  input  logic [ADDR_W-1:0] add_Rt,
  output logic [DATA_W-1:0] out_Rs,
  output logic [DATA_W-1:0] out_Rt,
  output logic [DATA_W-1:0] addr_sw,
  output logic [DATA_W-1:0] data_sw,
  input  logic              regwr,
  input  logic [ADDR_W-1:0] add_Rd,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              use_Rs,
  input  logic              use_Rt,
  output logic              busy_Rs,
  output logic              busy_Rt,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic              fwd_s;
  logic              fwd_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (regwr && add_Rd != R0) begin
      regs[add_Rd] <= data_wr;
    end
  end

  assign fwd_s = BYPASS && regwr && (add_Rd == add_Rs);
  assign fwd_t = BYPASS && regwr && (add_Rd == add_Rt);

  // Reads are forced to zero while reset is held so a bypassed write cannot leak through.
  always_comb begin
    out_Rs = '0;
    out_Rt = '0;
    if (!rst && add_Rs != R0) out_Rs = fwd_s ? data_wr : regs[add_Rs];
    if (!rst && add_Rt != R0) out_Rt = fwd_t ? data_wr : regs[add_Rt];
  end

  assign addr_sw = out_Rs;
  assign data_sw = out_Rt;

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .regwr   (regwr),
    .add_Rd  (add_Rd),
    .pend    (pend),
    .pend_cnt(pend_cnt)
  );

  assign busy_Rs = (add_Rs != R0) && pend[add_Rs] && !fwd_s;
  assign busy_Rt = (add_Rt != R0) && pend[add_Rt] && !fwd_t;
  assign stall   = (use_Rs && busy_Rs) || (use_Rt && busy_Rt);
endmodule
